mult_div_unit: RTL and testbench



---
 rtl/mult_div_pkg.sv | 14 +
 rtl/mult_div_core.sv | 34 +++
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and encodings for the iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_core.sv
// One iteration of the shift-add multiplier / restoring divider on magnitudes.
// Accumulator layout: multiply {partial_hi, multiplier}, divide {remainder, quotient}.
module mult_div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_op,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]       w_add;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_fits;
  logic [2*WIDTH-1:0]   w_div_next;

  // Multiply: add multiplicand when the current multiplier bit is set, keep the carry, shift right.
  assign w_add      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
  assign w_mul_next = i_acc[0] ? {w_add, i_acc[WIDTH-1:1]}
                               : {1'b0, i_acc[2*WIDTH-1:1]};

  // Divide: the shifted partial remainder needs one extra bit before the trial subtract.
  assign w_trial    = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
  assign w_fits     = (w_trial >= {1'b0, i_operand});
  assign w_diff     = w_trial[WIDTH-1:0] - i_operand;
  assign w_div_next = {(w_fits ? w_diff : w_trial[WIDTH-1:0]), i_acc[WIDTH-2:0], w_fits};

  assign o_acc = (i_op == OP_DIV) ? w_div_next : w_mul_next;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide with start/busy/done handshake and HI/LO result registers.
// Define MULT_DIV_DIV_ZERO_EXC_EN to trap divide-by-zero straight to DONE with a div_zero pulse.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_op;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_b_zero;
  logic [WIDTH-1:0]     r_operand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_div_zero;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_dz_trap;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

`ifdef MULT_DIV_DIV_ZERO_EXC_EN
  assign w_dz_trap = (op == OP_DIV) && (b == '0);
`else
  assign w_dz_trap = 1'b0;
`endif

  mult_div_core #(.WIDTH(WIDTH)) u_core (
    .i_op      (r_op),
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_acc     (w_acc_next)
  );

  // Sign correction applied during FIXUP; a zero divisor keeps the raw all-ones quotient.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_prod   = r_acc;
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (r_op == OP_MULT) begin
      w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else begin
      w_fix_hi = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      if (r_b_zero) begin
        w_fix_lo = '1;
      end else begin
        w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= OP_MULT;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_b_zero   <= 1'b0;
      r_operand  <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (w_dz_trap) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state   <= RUN;
              r_busy    <= 1'b1;
              r_cnt     <= CNT_LAST;
              r_op      <= op;
              r_sign_a  <= is_signed & a[WIDTH-1];
              r_sign_b  <= is_signed & b[WIDTH-1];
              r_b_zero  <= (b == '0);
              r_operand <= (op == OP_MULT) ? w_a_mag : w_b_mag;
              r_acc     <= {{WIDTH{1'b0}}, ((op == OP_MULT) ? w_b_mag : w_a_mag)};
            end
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt == '0) begin
            r_state <= FIXUP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        FIXUP: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH=32 and WIDTH=8, scoreboard on done.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op = 1'b0;
  logic        is_signed = 1'b0;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy32, done32, dz32;
  logic        busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

`ifdef MULT_DIV_DIV_ZERO_EXC_EN
  localparam bit DZ_EXC = 1'b1;
`else
  localparam bit DZ_EXC = 1'b0;
`endif

  typedef struct {
    bit          w8;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } exp_t;

  typedef struct {
    bit          w8;
    bit          op;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          restart;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  vec_t        vecs[15];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_hi32 = '0;
  logic [31:0] last_lo32 = '0;
  logic [31:0] last_hi8 = '0;
  logic [31:0] last_lo8 = '0;

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clock     (clock),
    .reset     (reset),
    .start     (start32),
    .op        (op),
    .is_signed (is_signed),
    .a         (a32),
    .b         (b32),
    .busy      (busy32),
    .done      (done32),
    .hi        (hi32),
    .lo        (lo32),
    .div_zero  (dz32)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clock     (clock),
    .reset     (reset),
    .start     (start8),
    .op        (op),
    .is_signed (is_signed),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .hi        (hi8),
    .lo        (lo8),
    .div_zero  (dz8)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic on sign- or zero-extended operands; divisor is never zero here.
  function automatic void model(input bit w8, input bit op_i, input bit sgn_i,
                                input logic [31:0] aa, input logic [31:0] bb,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    if (w8) begin
      sa  = sgn_i ? longint'($signed(aa[7:0])) : longint'({56'b0, aa[7:0]});
      sbv = sgn_i ? longint'($signed(bb[7:0])) : longint'({56'b0, bb[7:0]});
    end else begin
      sa  = sgn_i ? longint'($signed(aa)) : longint'({32'b0, aa});
      sbv = sgn_i ? longint'($signed(bb)) : longint'({32'b0, bb});
    end
    p = sa * sbv;
    q = sa / sbv;
    r = sa % sbv;
    if (!op_i) begin
      eh = w8 ? {24'b0, p[15:8]} : p[63:32];
      el = w8 ? {24'b0, p[7:0]}  : p[31:0];
    end else begin
      eh = w8 ? {24'b0, r[7:0]} : r[31:0];
      el = w8 ? {24'b0, q[7:0]} : q[31:0];
    end
  endfunction

  // Scoreboard: each done pops the oldest expectation.
  always @(negedge clock) begin
    if (reset && (done32 || done8)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        m_e = sb_q.pop_front();
        check("done_source_w8", 64'(done8), 64'(m_e.w8));
        if (m_e.w8) begin
          check("hi8", 64'(hi8), 64'(m_e.hi));
          check("lo8", 64'(lo8), 64'(m_e.lo));
          check("div_zero8", 64'(dz8), 64'(m_e.dz));
        end else begin
          check("hi32", 64'(hi32), 64'(m_e.hi));
          check("lo32", 64'(lo32), 64'(m_e.lo));
          check("div_zero32", 64'(dz32), 64'(m_e.dz));
        end
      end
    end
  end

  task automatic run_op(input bit w8, input bit op_i, input bit sgn_i,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] eh, input logic [31:0] el, input int restart);
    exp_t        x;
    bit          trap;
    int          lat;
    int          e;
    bit          seen;
    logic [31:0] ph;
    logic [31:0] pl;
    trap = DZ_EXC && op_i && (w8 ? (bb[7:0] == 8'h00) : (bb == 32'h0));
    ph   = w8 ? last_hi8 : last_hi32;
    pl   = w8 ? last_lo8 : last_lo32;
    x.w8 = w8;
    x.dz = trap;
    x.hi = trap ? ph : eh;
    x.lo = trap ? pl : el;
    lat  = trap ? 0 : (w8 ? 9 : 33);
    sb_q.push_back(x);
    if (w8) begin
      last_hi8 = x.hi;
      last_lo8 = x.lo;
    end else begin
      last_hi32 = x.hi;
      last_lo32 = x.lo;
    end
    @(negedge clock);
    op        = op_i;
    is_signed = sgn_i;
    if (w8) begin
      start8 = 1'b1;
      a8     = aa[7:0];
      b8     = bb[7:0];
    end else begin
      start32 = 1'b1;
      a32     = aa;
      b32     = bb;
    end
    @(posedge clock);
    e    = 0;
    seen = 1'b0;
    while (!seen && e <= lat + 4) begin
      @(negedge clock);
      if (e == 0) begin
        start8    = 1'b0;
        start32   = 1'b0;
        op        = 1'($urandom);
        is_signed = 1'($urandom);
        a32       = $urandom;
        b32       = $urandom;
        a8        = 8'($urandom);
        b8        = 8'($urandom);
        check("busy_after_start", 64'(w8 ? busy8 : busy32), 64'(!trap));
      end
      if (restart != 0 && e == restart - 1) begin
        if (w8) start8 = 1'b1;
        else    start32 = 1'b1;
      end
      if (restart != 0 && e == restart) begin
        start8  = 1'b0;
        start32 = 1'b0;
      end
      if (e == 5 && !trap) begin
        check("hi_held_in_run", 64'(w8 ? {24'b0, hi8} : hi32), 64'(ph));
        check("lo_held_in_run", 64'(w8 ? {24'b0, lo8} : lo32), 64'(pl));
      end
      if (w8 ? done8 : done32) begin
        seen = 1'b1;
        check("done_latency", 64'(e), 64'(lat));
        check("busy_at_done", 64'(w8 ? busy8 : busy32), 64'(0));
      end else begin
        @(posedge clock);
        e++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d edges, expected at edge %0d", e, lat);
    end
  endtask

  initial begin
    logic [31:0] rh;
    logic [31:0] rl;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rw8;
    bit          rop;
    bit          rsg;

    // w8, op, signed, a, b, expected hi, expected lo, restart edge
    vecs[0]  = '{0, 0, 0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 0};
    vecs[1]  = '{0, 0, 1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0};
    vecs[2]  = '{0, 1, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0};
    vecs[3]  = '{0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};
    vecs[4]  = '{0, 1, 0, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 0};
    vecs[5]  = '{0, 1, 1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0};
    vecs[6]  = '{0, 1, 1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0};
    vecs[7]  = '{0, 1, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 0};
    vecs[8]  = '{0, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};
    vecs[9]  = '{0, 1, 0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[10] = '{0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0};
    vecs[11] = '{0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0};
    vecs[12] = '{1, 0, 0, 32'h000000FF, 32'h000000FF, 32'h000000FE, 32'h00000001, 0};
    vecs[13] = '{1, 1, 0, 32'h000000C8, 32'h00000007, 32'h00000004, 32'h0000001C, 0};
    vecs[14] = '{1, 1, 1, 32'h00000080, 32'h000000FF, 32'h00000000, 32'h00000080, 0};

    #12;
    check("rst_busy32", 64'(busy32), 64'(0));
    check("rst_done32", 64'(done32), 64'(0));
    check("rst_hi32", 64'(hi32), 64'(0));
    check("rst_lo32", 64'(lo32), 64'(0));
    check("rst_dz32", 64'(dz32), 64'(0));
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_hi8", 64'(hi8), 64'(0));
    check("rst_lo8", 64'(lo8), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].w8, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].restart);
    end

    // Reset in the middle of a 32-bit multiply.
    @(negedge clock);
    op        = 1'b0;
    is_signed = 1'b0;
    a32       = 32'h0000BEEF;
    b32       = 32'h00001001;
    start32   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    repeat (14) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy32), 64'(0));
    check("midrst_done", 64'(done32), 64'(0));
    check("midrst_hi", 64'(hi32), 64'(0));
    check("midrst_lo", 64'(lo32), 64'(0));
    last_hi32 = '0;
    last_lo32 = '0;
    last_hi8  = '0;
    last_lo8  = '0;
    @(negedge clock);
    reset = 1'b1;
    run_op(1'b0, 1'b0, 1'b0, 32'h00000006, 32'h00000007, 32'h0, 32'h0000002A, 0);

    for (int i = 0; i < 8; i++) begin
      rw8 = 1'($urandom);
      rop = 1'($urandom);
      rsg = 1'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if (rb[7:0] == 8'h00) rb[0] = 1'b1;
      model(rw8, rop, rsg, ra, rb, rh, rl);
      run_op(rw8, rop, rsg, ra, rb, rh, rl, 0);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
